// File: rtl/ps2_pkg.sv
// Shared definitions for the PS/2 keyboard receiver: frame state encoding,
// special scan-code bytes and the layout of the key event word.
package ps2_pkg;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_DATA   = 2'd1,
        ST_PARITY = 2'd2,
        ST_STOP   = 2'd3
    } frame_state_e;

    localparam logic [7:0] BYTE_E0 = 8'hE0;
    localparam logic [7:0] BYTE_E1 = 8'hE1;
    localparam logic [7:0] BYTE_F0 = 8'hF0;

    // Pause/Break is E1 followed by seven more bytes that must be swallowed.
    localparam logic [2:0] PAUSE_SKIP = 3'd7;

    localparam int KEY_W        = 11;
    localparam int TOGGLE_BIT   = 10;
    localparam int PRESSED_BIT  = 9;
    localparam int EXTENDED_BIT = 8;
    localparam int CODE_MSB     = 7;
    localparam int CODE_LSB     = 0;

    // Keyboard status/response bytes that never represent a key on their own.
    function automatic logic is_discard(input logic [7:0] code);
        case (code)
            8'h00, 8'hAA, 8'hEE, 8'hFA, 8'hFC, 8'hFE, 8'hFF: is_discard = 1'b1;
            default:                                       is_discard = 1'b0;
        endcase
    endfunction

endpackage

// File: rtl/ps2_filter.sv
// Synchronizes one asynchronous PS/2 line into clk_sys and debounces it:
// the output level only follows the input after FILTER_LEN consecutive
// cycles of disagreement, so short glitches never reach the frame logic.
module ps2_filter #(
    parameter int FILTER_LEN = 8
) (
    input  logic clk_sys,
    input  logic reset_n,
    input  logic line_i,
    output logic level_o
);

    localparam int              CNT_W    = (FILTER_LEN > 1) ? $clog2(FILTER_LEN) : 1;
    localparam logic [CNT_W-1:0] CNT_LOAD = CNT_W'(FILTER_LEN - 1);

    logic             sync1_q;
    logic             sync2_q;
    logic             level_q;
    logic             level_d;
    logic [CNT_W-1:0] cnt_q;
    logic [CNT_W-1:0] cnt_d;

    // Two-flop synchronizer; idle-high lines reset to 1.
    always_ff @(posedge clk_sys or negedge reset_n) begin
        if (!reset_n) begin
            sync1_q <= 1'b1;
            sync2_q <= 1'b1;
        end else begin
            sync1_q <= line_i;
            sync2_q <= sync1_q;
        end
    end

    // Down-counter reloads whenever the input agrees; the level flips on the
    // FILTER_LEN-th consecutive disagreeing cycle.
    always_comb begin
        level_d = level_q;
        cnt_d   = cnt_q;
        if (sync2_q == level_q) begin
            cnt_d = CNT_LOAD;
        end else if (cnt_q == '0) begin
            level_d = sync2_q;
            cnt_d   = CNT_LOAD;
        end else begin
            cnt_d = cnt_q - 1'b1;
        end
    end

    // Filtered level and debounce timer registers.
    always_ff @(posedge clk_sys or negedge reset_n) begin
        if (!reset_n) begin
            level_q <= 1'b1;
            cnt_q   <= CNT_LOAD;
        end else begin
            level_q <= level_d;
            cnt_q   <= cnt_d;
        end
    end

    assign level_o = level_q;

endmodule

// File: rtl/ps2_key_rx.sv
// PS/2 keyboard receiver: filters both lines, deframes 11-bit PS/2 frames
// on filtered clock falling edges, and decodes scan-code bytes into key
// events {toggle, pressed, extended, code}.
//
// state     | meaning
// ----------+----------------------------------------------------------
// ST_IDLE   | waiting for a start bit (sampled 0)
// ST_DATA   | shifting in 8 data bits, LSB first
// ST_PARITY | sampling the odd-parity bit
// ST_STOP   | sampling the stop bit; accept or reject the frame
module ps2_key_rx
    import ps2_pkg::*;
#(
    parameter int FILTER_LEN     = 8,
    parameter int TIMEOUT_CYCLES = 100000
) (
    input  logic             clk_sys,
    input  logic             reset_n,
    input  logic             ps2_clk,
    input  logic             ps2_data,
    output logic [KEY_W-1:0] ps2_key,
    output logic             err
);

    localparam int              TO_W     = $clog2(TIMEOUT_CYCLES + 1);
    localparam logic [TO_W-1:0] TO_LIMIT = TO_W'(TIMEOUT_CYCLES);

    logic clk_filt;
    logic data_filt;
    logic clk_prev_q;
    logic fall;

    frame_state_e    state_q;
    frame_state_e    state_d;
    logic [2:0]      bit_cnt_q;
    logic [2:0]      bit_cnt_d;
    logic [7:0]      shift_q;
    logic [7:0]      shift_d;
    logic            par_ok_q;
    logic            par_ok_d;
    logic [TO_W-1:0] to_cnt_q;
    logic [TO_W-1:0] to_cnt_d;
    logic            err_q;
    logic            err_d;
    logic            accept;
    logic            frame_bad;
    logic            timeout_hit;

    logic             ext_q;
    logic             ext_d;
    logic             brk_q;
    logic             brk_d;
    logic [2:0]       skip_q;
    logic [2:0]       skip_d;
    logic [KEY_W-1:0] key_q;
    logic [KEY_W-1:0] key_d;

    ps2_filter #(.FILTER_LEN(FILTER_LEN)) u_clk_filter (
        .clk_sys (clk_sys),
        .reset_n (reset_n),
        .line_i  (ps2_clk),
        .level_o (clk_filt)
    );

    ps2_filter #(.FILTER_LEN(FILTER_LEN)) u_data_filter (
        .clk_sys (clk_sys),
        .reset_n (reset_n),
        .line_i  (ps2_data),
        .level_o (data_filt)
    );

    // Previous filtered clock level, for falling-edge detection.
    always_ff @(posedge clk_sys or negedge reset_n) begin
        if (!reset_n) begin
            clk_prev_q <= 1'b1;
        end else begin
            clk_prev_q <= clk_filt;
        end
    end

    assign fall = clk_prev_q & ~clk_filt;

    // Frame FSM next state, inter-edge timeout and accept/reject strobes.
    always_comb begin
        state_d     = state_q;
        bit_cnt_d   = bit_cnt_q;
        shift_d     = shift_q;
        par_ok_d    = par_ok_q;
        to_cnt_d    = to_cnt_q;
        accept      = 1'b0;
        frame_bad   = 1'b0;
        timeout_hit = 1'b0;

        if (state_q == ST_IDLE || fall) begin
            to_cnt_d = '0;
        end else if (to_cnt_q == TO_LIMIT) begin
            timeout_hit = 1'b1;
            to_cnt_d    = '0;
        end else begin
            to_cnt_d = to_cnt_q + 1'b1;
        end

        if (timeout_hit) begin
            state_d = ST_IDLE;
        end else if (fall) begin
            case (state_q)
                ST_IDLE: begin
                    if (!data_filt) begin
                        state_d   = ST_DATA;
                        bit_cnt_d = 3'd0;
                    end
                end
                ST_DATA: begin
                    shift_d   = {data_filt, shift_q[7:1]};
                    bit_cnt_d = bit_cnt_q + 3'd1;
                    if (bit_cnt_q == 3'd7) begin
                        state_d = ST_PARITY;
                    end
                end
                ST_PARITY: begin
                    par_ok_d = ^{shift_q, data_filt};
                    state_d  = ST_STOP;
                end
                ST_STOP: begin
                    if (data_filt && par_ok_q) begin
                        accept = 1'b1;
                    end else begin
                        frame_bad = 1'b1;
                    end
                    state_d = ST_IDLE;
                end
                default: state_d = ST_IDLE;
            endcase
        end

        err_d = frame_bad | timeout_hit;
    end

    // Frame FSM registers.
    always_ff @(posedge clk_sys or negedge reset_n) begin
        if (!reset_n) begin
            state_q   <= ST_IDLE;
            bit_cnt_q <= 3'd0;
            shift_q   <= 8'h00;
            par_ok_q  <= 1'b0;
            to_cnt_q  <= '0;
            err_q     <= 1'b0;
        end else begin
            state_q   <= state_d;
            bit_cnt_q <= bit_cnt_d;
            shift_q   <= shift_d;
            par_ok_q  <= par_ok_d;
            to_cnt_q  <= to_cnt_d;
            err_q     <= err_d;
        end
    end

    // Byte decoder: prefix flags, Pause skip window, discard list, event word.
    always_comb begin
        ext_d  = ext_q;
        brk_d  = brk_q;
        skip_d = skip_q;
        key_d  = key_q;

        if (frame_bad) begin
            ext_d = 1'b0;
            brk_d = 1'b0;
        end else if (accept) begin
            if (skip_q != 3'd0) begin
                skip_d = skip_q - 3'd1;
            end else if (shift_q == BYTE_E1) begin
                skip_d = PAUSE_SKIP;
            end else if (shift_q == BYTE_E0) begin
                ext_d = 1'b1;
            end else if (shift_q == BYTE_F0) begin
                brk_d = 1'b1;
            end else if (!ext_q && !brk_q && is_discard(shift_q)) begin
                key_d = key_q;
            end else begin
                key_d[TOGGLE_BIT]         = ~key_q[TOGGLE_BIT];
                key_d[PRESSED_BIT]        = ~brk_q;
                key_d[EXTENDED_BIT]       = ext_q;
                key_d[CODE_MSB:CODE_LSB]  = shift_q;
                ext_d                     = 1'b0;
                brk_d                     = 1'b0;
            end
        end
    end

    // Decoder registers.
    always_ff @(posedge clk_sys or negedge reset_n) begin
        if (!reset_n) begin
            ext_q  <= 1'b0;
            brk_q  <= 1'b0;
            skip_q <= 3'd0;
            key_q  <= '0;
        end else begin
            ext_q  <= ext_d;
            brk_q  <= brk_d;
            skip_q <= skip_d;
            key_q  <= key_d;
        end
    end

    assign ps2_key = key_q;
    assign err     = err_q;

endmodule
